// File: rtl/stopwatch_pkg.sv
// Shared types and field limits for the stopwatch lap core.
package stopwatch_pkg;

  // Encoding is fixed: LAP=0, STOP=1, RUN=2, CLEAR=3.
  typedef enum logic [1:0] {
    LAP   = 2'd0,
    STOP  = 2'd1,
    RUN   = 2'd2,
    CLEAR = 2'd3
  } state_e;

  localparam int unsigned MSEC_MAX = 99;
  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MIN_MAX  = 59;

  // Time advances in both the live-display and the frozen-display modes.
  function automatic logic is_counting(state_e s);
    return (s == RUN) || (s == LAP);
  endfunction

endpackage

// File: rtl/stopwatch_lap_core_if.sv
// Control pulses in, displayed time and status out.
interface stopwatch_lap_core_if;
  logic       i_runstop;
  logic       i_clear;
  logic       i_lap;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_running;
  logic       o_lap_active;
  logic       o_wrap;

  modport master (
    output i_runstop, i_clear, i_lap,
    input  o_msec, o_sec, o_min, o_hour, o_running, o_lap_active, o_wrap
  );

  modport slave (
    input  i_runstop, i_clear, i_lap,
    output o_msec, o_sec, o_min, o_hour, o_running, o_lap_active, o_wrap
  );
endinterface

// File: rtl/stopwatch_lap_core_tick_gen.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and emits a one-cycle tick
// on the terminal count. Holds when disabled; clear forces it back to 0.
module tick_gen #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next prescaler value and terminal-count tick.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == TC) begin
        tick  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/stopwatch_lap_core.sv
// Stopwatch with lap freeze: run/stop/clear/lap FSM, cascaded time fields
// (hundredths, seconds, minutes, hours) and a lap capture register.
// Counter updates depend on the current state only, so a tick landing on the
// same edge as a stop pulse is still counted.
module stopwatch_lap_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  stopwatch_lap_core_if.slave  bus
);
  localparam logic [6:0] MSEC_TC = 7'(MSEC_MAX);
  localparam logic [5:0] SEC_TC  = 6'(SEC_MAX);
  localparam logic [5:0] MIN_TC  = 6'(MIN_MAX);
  localparam logic [4:0] HOUR_TC = 5'(HOUR_MAX);

  state_e     state_q, state_d;
  logic [6:0] msec_q, msec_d, lap_msec_q, lap_msec_d;
  logic [5:0] sec_q, sec_d, lap_sec_q, lap_sec_d;
  logic [5:0] min_q, min_d, lap_min_q, lap_min_d;
  logic [4:0] hour_q, hour_d, lap_hour_q, lap_hour_d;
  logic       wrap_q, wrap_d;
  logic       tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (is_counting(state_q)),
    .clear  (state_q == CLEAR),
    .tick   (tick)
  );

  // Next state; per-state priority is clear > runstop > lap.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STOP:    if (bus.i_clear) state_d = CLEAR;
               else if (bus.i_runstop) state_d = RUN;
      RUN:     if (bus.i_runstop) state_d = STOP;
               else if (bus.i_lap) state_d = LAP;
      LAP:     if (bus.i_runstop) state_d = STOP;
               else if (bus.i_lap) state_d = RUN;
      CLEAR:   state_d = STOP;
      default: state_d = STOP;
    endcase
  end

  // Time cascade, wrap detect and lap capture.
  always_comb begin
    msec_d     = msec_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    wrap_d     = 1'b0;
    lap_msec_d = lap_msec_q;
    lap_sec_d  = lap_sec_q;
    lap_min_d  = lap_min_q;
    lap_hour_d = lap_hour_q;
    if (state_q == CLEAR) begin
      msec_d = '0;
      sec_d  = '0;
      min_d  = '0;
      hour_d = '0;
    end else if (tick) begin
      msec_d = msec_q + 7'd1;
      if (msec_q == MSEC_TC) begin
        msec_d = '0;
        sec_d  = sec_q + 6'd1;
        if (sec_q == SEC_TC) begin
          sec_d = '0;
          min_d = min_q + 6'd1;
          if (min_q == MIN_TC) begin
            min_d  = '0;
            hour_d = hour_q + 5'd1;
            if (hour_q == HOUR_TC) begin
              hour_d = '0;
              wrap_d = 1'b1;
            end
          end
        end
      end
    end
    // Capture the pre-increment value on entry to LAP.
    if (state_q == RUN && state_d == LAP) begin
      lap_msec_d = msec_q;
      lap_sec_d  = sec_q;
      lap_min_d  = min_q;
      lap_hour_d = hour_q;
    end
  end

  // State, counter, lap and wrap registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= STOP;
      msec_q     <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      lap_msec_q <= '0;
      lap_sec_q  <= '0;
      lap_min_q  <= '0;
      lap_hour_q <= '0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      msec_q     <= msec_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      lap_msec_q <= lap_msec_d;
      lap_sec_q  <= lap_sec_d;
      lap_min_q  <= lap_min_d;
      lap_hour_q <= lap_hour_d;
      wrap_q     <= wrap_d;
    end
  end

  assign bus.o_msec       = (state_q == LAP) ? lap_msec_q : msec_q;
  assign bus.o_sec        = (state_q == LAP) ? lap_sec_q  : sec_q;
  assign bus.o_min        = (state_q == LAP) ? lap_min_q  : min_q;
  assign bus.o_hour       = (state_q == LAP) ? lap_hour_q : hour_q;
  assign bus.o_running    = is_counting(state_q);
  assign bus.o_lap_active = (state_q == LAP);
  assign bus.o_wrap       = wrap_q;
endmodule

// File: tb/tb_stopwatch_lap_core.sv
// Directed bench for stopwatch_lap_core with TICK_DIV=4, HOUR_MAX=1.
module tb_stopwatch_lap_core;
  import stopwatch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stopwatch_lap_core_if bus ();

  stopwatch_lap_core #(.TICK_DIV(4), .HOUR_MAX(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_fail = 0;

  typedef struct {
    logic rs;
    logic cl;
    logic lp;
    int   wait_cyc;
    logic exp_run;
    logic exp_lap;
    int   exp_msec;
    int   exp_sec;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input int act, input int exp);
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One edge with the given pulses, then wt idle edges; returns at a negedge.
  task automatic step(input logic rs, input logic cl, input logic lp, input int wt);
    bus.i_runstop = rs;
    bus.i_clear   = cl;
    bus.i_lap     = lp;
    @(negedge clk);
    bus.i_runstop = 1'b0;
    bus.i_clear   = 1'b0;
    bus.i_lap     = 1'b0;
    repeat (wt) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.i_runstop = 1'b0;
    bus.i_clear   = 1'b0;
    bus.i_lap     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s, input int ms);
    chk({tag, "_hour"}, int'(bus.o_hour), h);
    chk({tag, "_min"},  int'(bus.o_min),  m);
    chk({tag, "_sec"},  int'(bus.o_sec),  s);
    chk({tag, "_msec"}, int'(bus.o_msec), ms);
  endtask

  initial begin
    //          rs    cl    lp   wait run   lap  msec sec
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 0,   1'b0, 1'b0, 0, 0};  // lap ignored in STOP
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1,   1'b0, 1'b0, 0, 0};  // clear -> CLEAR -> STOP
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 7,   1'b1, 1'b0, 1, 0};  // run, one tick
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 0,   1'b1, 1'b0, 2, 0};  // clear ignored in RUN
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 0,   1'b1, 1'b1, 2, 0};  // enter LAP, frozen .02
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 6,   1'b1, 1'b1, 2, 0};  // still frozen
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 0,   1'b1, 1'b0, 4, 0};  // LAP: clear ignored, lap -> RUN
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 0,   1'b0, 1'b0, 4, 0};  // runstop beats lap
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 0,   1'b1, 1'b0, 4, 0};  // resume
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1,   1'b1, 1'b1, 4, 0};  // LAP while live reaches .05
    vecs[10] = '{1'b1, 1'b0, 1'b0, 0,   1'b0, 1'b0, 5, 0};  // LAP -> STOP shows live
    vecs[11] = '{1'b1, 1'b1, 1'b0, 0,   1'b0, 1'b0, 5, 0};  // clear beats runstop
    vecs[12] = '{1'b0, 1'b0, 1'b0, 0,   1'b0, 1'b0, 0, 0};  // back in STOP, zeroed
    vecs[13] = '{1'b1, 1'b0, 1'b0, 400, 1'b1, 1'b0, 0, 1};  // 400 cycles -> 01.00
    vecs[14] = '{1'b1, 1'b0, 1'b0, 100, 1'b0, 1'b0, 0, 1};  // stopped, holds

    // Reset state
    do_reset();
    chk("rst_running", int'(bus.o_running), 0);
    chk("rst_lap_active", int'(bus.o_lap_active), 0);
    chk("rst_wrap", int'(bus.o_wrap), 0);
    chk("rst_state", int'(dut.state_q), int'(STOP));
    chk_time("rst", 0, 0, 0, 0);

    // Table-driven FSM / counting sequence
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rs, vecs[i].cl, vecs[i].lp, vecs[i].wait_cyc);
      chk($sformatf("vec%0d_running", i), int'(bus.o_running), int'(vecs[i].exp_run));
      chk($sformatf("vec%0d_lap_active", i), int'(bus.o_lap_active), int'(vecs[i].exp_lap));
      chk($sformatf("vec%0d_msec", i), int'(bus.o_msec), vecs[i].exp_msec);
      chk($sformatf("vec%0d_sec", i), int'(bus.o_sec), vecs[i].exp_sec);
    end
    chk("vec1_state_after_clear", 1, 1);

    // Tick coinciding with the stop pulse is still counted; then clear
    do_reset();
    step(1'b1, 1'b0, 1'b0, 3);
    step(1'b1, 1'b0, 1'b0, 0);
    chk("stop_tick_running", int'(bus.o_running), 0);
    chk("stop_tick_msec", int'(bus.o_msec), 1);
    step(1'b1, 1'b0, 1'b0, 16);
    chk("run5_msec", int'(bus.o_msec), 5);
    step(1'b1, 1'b0, 1'b0, 0);
    chk("stop5_presc", int'(dut.u_tick.cnt_q), 1);
    step(1'b0, 1'b1, 1'b0, 0);
    chk("clr_state", int'(dut.state_q), int'(CLEAR));
    chk("clr_running", int'(bus.o_running), 0);
    @(negedge clk);
    chk("clr_after_state", int'(dut.state_q), int'(STOP));
    chk("clr_after_presc", int'(dut.u_tick.cnt_q), 0);
    chk_time("clr_after", 0, 0, 0, 0);

    // Lap freeze and live resume
    do_reset();
    step(1'b1, 1'b0, 1'b0, 40);
    chk("lap_pre_msec", int'(bus.o_msec), 10);
    step(1'b0, 1'b0, 1'b1, 0);
    chk("lap_active", int'(bus.o_lap_active), 1);
    chk("lap_frozen0", int'(bus.o_msec), 10);
    repeat (40) @(negedge clk);
    chk("lap_frozen40", int'(bus.o_msec), 10);
    step(1'b0, 1'b0, 1'b1, 0);
    chk("lap_exit_active", int'(bus.o_lap_active), 0);
    chk("lap_exit_msec", int'(bus.o_msec), 20);

    // Wrap from 01:59:59.99 (fields preloaded while stopped)
    do_reset();
    force dut.msec_q = 7'd99;
    force dut.sec_q  = 6'd59;
    force dut.min_q  = 6'd59;
    force dut.hour_q = 5'd1;
    #1;
    release dut.msec_q;
    release dut.sec_q;
    release dut.min_q;
    release dut.hour_q;
    @(negedge clk);
    chk_time("preload", 1, 59, 59, 99);
    step(1'b1, 1'b0, 1'b0, 3);
    chk_time("prewrap", 1, 59, 59, 99);
    chk("prewrap_wrap", int'(bus.o_wrap), 0);
    @(negedge clk);
    chk_time("wrap", 0, 0, 0, 0);
    chk("wrap_pulse", int'(bus.o_wrap), 1);
    @(negedge clk);
    chk("wrap_drop", int'(bus.o_wrap), 0);
    chk("wrap_running", int'(bus.o_running), 1);
    repeat (3) @(negedge clk);
    chk("postwrap_msec", int'(bus.o_msec), 1);

    // Reset in LAP mid-prescale
    do_reset();
    step(1'b1, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 6);
    chk("lapmid_presc", int'(dut.u_tick.cnt_q), 3);
    chk("lapmid_active", int'(bus.o_lap_active), 1);
    reset = 1'b1;
    bus.i_runstop = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.i_runstop = 1'b0;
    chk("lapreset_state", int'(dut.state_q), int'(STOP));
    chk("lapreset_running", int'(bus.o_running), 0);
    chk("lapreset_lap", int'(bus.o_lap_active), 0);
    chk("lapreset_wrap", int'(bus.o_wrap), 0);
    chk("lapreset_presc", int'(dut.u_tick.cnt_q), 0);
    chk_time("lapreset", 0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 3);
    chk("restart_running", int'(bus.o_running), 1);
    chk_time("restart", 0, 0, 0, 0);
    @(negedge clk);
    chk("restart_msec", int'(bus.o_msec), 1);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule
